// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch unit.
//   WORD_DEFAULT   default datapath / PC width
//   BR_TYPE_BIT    instruction bit selecting conditional (1) vs branch-with-link (0)
//   CC_MSB/CC_LSB  condition-code field position in the instruction word
//   CC_*           condition-code encodings
//   state_e        branch FSM states
package branch_pkg;

  localparam int WORD_DEFAULT = 16;

  localparam int BR_TYPE_BIT = 13;
  localparam int CC_MSB      = 12;
  localparam int CC_LSB      = 10;

  localparam logic [2:0] CC_EQ = 3'b000;
  localparam logic [2:0] CC_NE = 3'b001;
  localparam logic [2:0] CC_CS = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] CC_MI = 3'b100;
  localparam logic [2:0] CC_GE = 3'b101;
  localparam logic [2:0] CC_LT = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    LINK   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational condition-code evaluator.
//   cond_i   [2:0]  condition code
//   flags_i  [3:0]  flags {N,Z,C,V}
//   taken_o         1 when the condition holds
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = flags_i[3];
  assign z = flags_i[2];
  assign c = flags_i[1];
  assign v = flags_i[0];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_EQ:   taken_o = z;
      CC_NE:   taken_o = !z;
      CC_CS:   taken_o = c;
      CC_CC:   taken_o = !c;
      CC_MI:   taken_o = n;
      CC_GE:   taken_o = (n == v);
      CC_LT:   taken_o = (n != v);
      CC_AL:   taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: program counter plus multi-cycle branch sequencer.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               begin branch (IDLE only)
//   instWord_i            branch instruction (bit 13 type, bits 12:10 cond)
//   branchOffs_i          pre-sign-extended word offset
//   flags_i               {N,Z,C,V}, captured on start
//   pcLoad_i/pcLoadVal_i  direct PC load (IDLE only, bit 0 cleared)
//   pcInc_i               PC += 2 (IDLE only)
//   pc_o                  program counter
//   lrWrEn_o/lrData_o     link register write strobe / data
//   busy_o/done_o/taken_o status; taken_o valid with done_o
//   dbg_state_o           current FSM state for observation
// Handshake: start_i is a request accepted only when busy_o is low; done_o
// is a single-cycle pulse and no acknowledgement is required.
module branch_unit
  import branch_pkg::*;
#(
  parameter int WORD = WORD_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [WORD-1:0] instWord_i,
  input  logic [WORD-1:0] branchOffs_i,
  input  logic [3:0]      flags_i,
  input  logic            pcLoad_i,
  input  logic [WORD-1:0] pcLoadVal_i,
  input  logic            pcInc_i,
  output logic [WORD-1:0] pc_o,
  output logic            lrWrEn_o,
  output logic [WORD-1:0] lrData_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            taken_o,
  output logic [2:0]      dbg_state_o
);

  localparam logic [WORD-1:0] PC_STEP = WORD'(2);

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] inst_q, inst_d;
  logic [WORD-1:0] offs_q, offs_d;
  logic [3:0]      flags_q, flags_d;
  logic [WORD-1:0] lr_q, lr_d;
  logic            taken_q, taken_d;
  logic            cond_taken;

  // Only the type bit and condition field of the instruction matter, the
  // shifted-out offset MSB is intentionally dropped, and PC loads are
  // halfword aligned.
  logic unused_bits;
  assign unused_bits = ^{inst_q[WORD-1:BR_TYPE_BIT+1], inst_q[CC_LSB-1:0],
                         offs_q[WORD-1], pcLoadVal_i[0]};

  cond_eval u_cond_eval (
    .cond_i  (inst_q[CC_MSB:CC_LSB]),
    .flags_i (flags_q),
    .taken_o (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    offs_d  = offs_q;
    flags_d = flags_q;
    lr_d    = lr_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (pcLoad_i) begin
          pc_d = {pcLoadVal_i[WORD-1:1], 1'b0};
        end else if (start_i) begin
          inst_d  = instWord_i;
          offs_d  = branchOffs_i;
          flags_d = flags_i;
          state_d = EVAL;
        end else if (pcInc_i) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      EVAL: begin
        if (!inst_q[BR_TYPE_BIT]) begin
          taken_d = 1'b1;
          state_d = LINK;
        end else if (cond_taken) begin
          taken_d = 1'b1;
          state_d = UPDATE;
        end else begin
          taken_d = 1'b0;
          state_d = DONE;
        end
      end
      LINK: begin
        // PC has not moved since start, so it is the return address.
        lr_d    = pc_q;
        state_d = UPDATE;
      end
      UPDATE: begin
        pc_d    = pc_q + {offs_q[WORD-2:0], 1'b0};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      offs_q  <= '0;
      flags_q <= '0;
      lr_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      offs_q  <= offs_d;
      flags_q <= flags_d;
      lr_q    <= lr_d;
      taken_q <= taken_d;
    end
  end

  // Status decoded from state so a reset drops strobes immediately.
  assign pc_o        = pc_q;
  assign lrWrEn_o    = (state_q == LINK);
  assign lrData_o    = (state_q == LINK) ? pc_q : lr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign taken_o     = (state_q == DONE) && taken_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] instWord_i = '0;
  logic [15:0] branchOffs_i = '0;
  logic [3:0]  flags_i = '0;
  logic        pcLoad_i = 1'b0;
  logic [15:0] pcLoadVal_i = '0;
  logic        pcInc_i = 1'b0;
  logic [15:0] pc_o;
  logic        lrWrEn_o;
  logic [15:0] lrData_o;
  logic        busy_o;
  logic        done_o;
  logic        taken_o;
  logic [2:0]  dbg_state_o;

  int total = 0;
  int bad = 0;
  logic [15:0] last_lr = '0;

  typedef struct {
    logic [15:0] pc0;
    logic [15:0] inst;
    logic [15:0] offs;
    logic [3:0]  flags;
    logic [3:0]  flags_late;
    logic        noise;
    logic        exp_taken;
    logic [15:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  branch_unit #(.WORD(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .instWord_i   (instWord_i),
    .branchOffs_i (branchOffs_i),
    .flags_i      (flags_i),
    .pcLoad_i     (pcLoad_i),
    .pcLoadVal_i  (pcLoadVal_i),
    .pcInc_i      (pcInc_i),
    .pc_o         (pc_o),
    .lrWrEn_o     (lrWrEn_o),
    .lrData_o     (lrData_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .taken_o      (taken_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic load_pc(input logic [15:0] val);
    pcLoad_i = 1'b1;
    pcLoadVal_i = val;
    @(negedge clk_i);
    pcLoad_i = 1'b0;
  endtask

  task automatic start_branch(input logic [15:0] inst, input logic [15:0] offs,
                              input logic [3:0] flags);
    instWord_i = inst;
    branchOffs_i = offs;
    flags_i = flags;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int lr_cnt;
    logic [15:0] lr_seen;
    logic exp_bl;
    exp_bl = !v.inst[13];
    lr_cnt = 0;
    lr_seen = '0;
    load_pc(v.pc0);
    chk("pc_load", pc_o, v.pc0);
    start_branch(v.inst, v.offs, v.flags);
    flags_i = v.flags_late;
    if (v.noise) begin
      start_i = 1'b1;
      pcInc_i = 1'b1;
      pcLoad_i = 1'b1;
      pcLoadVal_i = 16'h5554;
      instWord_i = 16'h3C00;
    end
    cyc = 1;
    while (!done_o && cyc < 10) begin
      chk("busy", busy_o, 1);
      chk("taken_early", taken_o, 0);
      chk("pc_hold", pc_o, v.pc0);
      if (lrWrEn_o) begin
        lr_cnt++;
        lr_seen = lrData_o;
      end
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    pcInc_i = 1'b0;
    pcLoad_i = 1'b0;
    chk("latency", cyc, v.exp_lat);
    chk("done", done_o, 1);
    chk("taken", taken_o, v.exp_taken);
    chk("lr_writes", lr_cnt, exp_bl ? 1 : 0);
    if (exp_bl) begin
      chk("lr_data", lr_seen, v.pc0);
      last_lr = v.pc0;
    end
    chk("lr_hold", lrData_o, last_lr);
    chk("pc_done", pc_o, v.exp_pc);
    @(negedge clk_i);
    chk("done_pulse", done_o, 0);
    chk("idle", busy_o, 0);
    chk("pc_after", pc_o, v.exp_pc);
  endtask

  initial begin
    //           pc0       inst      offs      flg    late   noise tk  exp_pc    lat
    vecs.push_back('{16'h0100, 16'h0000, 16'h0010, 4'h0, 4'h0, 1'b0, 1'b1, 16'h0120, 4}); // BL
    vecs.push_back('{16'h0100, 16'h2000, 16'h0010, 4'h0, 4'h4, 1'b0, 1'b0, 16'h0100, 2}); // EQ Z=0
    vecs.push_back('{16'h0100, 16'h3C00, 16'hFFFE, 4'h0, 4'h0, 1'b0, 1'b1, 16'h00FC, 3}); // AL back
    vecs.push_back('{16'hFFF0, 16'h3C00, 16'h0010, 4'h0, 4'h0, 1'b0, 1'b1, 16'h0010, 3}); // AL wrap
    vecs.push_back('{16'h0200, 16'h2000, 16'h0004, 4'h4, 4'h0, 1'b1, 1'b1, 16'h0208, 3}); // EQ Z=1
    vecs.push_back('{16'h0200, 16'h2400, 16'h0004, 4'h4, 4'h0, 1'b0, 1'b0, 16'h0200, 2}); // NE Z=1
    vecs.push_back('{16'h0300, 16'h2800, 16'h0001, 4'h2, 4'h0, 1'b0, 1'b1, 16'h0302, 3}); // CS C=1
    vecs.push_back('{16'h0300, 16'h2C00, 16'h0001, 4'h2, 4'h0, 1'b1, 1'b0, 16'h0300, 2}); // CC C=1
    vecs.push_back('{16'h0400, 16'h3000, 16'h0008, 4'h8, 4'h0, 1'b0, 1'b1, 16'h0410, 3}); // MI N=1
    // GE / LT sweep over N,V; N is flipped after start
    vecs.push_back('{16'h0500, 16'h3400, 16'h0020, 4'h0, 4'h8, 1'b0, 1'b1, 16'h0540, 3});
    vecs.push_back('{16'h0500, 16'h3400, 16'h0020, 4'h1, 4'h9, 1'b0, 1'b0, 16'h0500, 2});
    vecs.push_back('{16'h0500, 16'h3400, 16'h0020, 4'h8, 4'h0, 1'b0, 1'b0, 16'h0500, 2});
    vecs.push_back('{16'h0500, 16'h3400, 16'h0020, 4'h9, 4'h1, 1'b0, 1'b1, 16'h0540, 3});
    vecs.push_back('{16'h0500, 16'h3800, 16'h0020, 4'h0, 4'h8, 1'b0, 1'b0, 16'h0500, 2});
    vecs.push_back('{16'h0500, 16'h3800, 16'h0020, 4'h1, 4'h9, 1'b0, 1'b1, 16'h0540, 3});
    vecs.push_back('{16'h0500, 16'h3800, 16'h0020, 4'h8, 4'h0, 1'b0, 1'b1, 16'h0540, 3});
    vecs.push_back('{16'h0500, 16'h3800, 16'h0020, 4'h9, 4'h1, 1'b0, 1'b0, 16'h0500, 2});
    // BL ignores condition bits; negative offset; noise while busy
    vecs.push_back('{16'h0800, 16'h1C00, 16'hFFF0, 4'h0, 4'hF, 1'b1, 1'b1, 16'h07E0, 4});

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_taken", taken_o, 0);
    chk("rst_lrwr", lrWrEn_o, 0);
    chk("rst_lrdata", lrData_o, 16'h0000);
    rst_i = 1'b0;
    // first edge after release is processed in IDLE
    pcInc_i = 1'b1;
    @(negedge clk_i);
    pcInc_i = 1'b0;
    chk("first_inc", pc_o, 16'h0002);

    // PC increment with wrap, load aligns bit 0
    load_pc(16'hFFFE);
    pcInc_i = 1'b1;
    @(negedge clk_i);
    pcInc_i = 1'b0;
    chk("inc_wrap", pc_o, 16'h0000);
    load_pc(16'h1235);
    chk("load_align", pc_o, 16'h1234);

    // pcLoad beats start and pcInc
    pcLoad_i = 1'b1; pcLoadVal_i = 16'h0100;
    start_i = 1'b1; pcInc_i = 1'b1; instWord_i = 16'h3C00; branchOffs_i = 16'h0004;
    @(negedge clk_i);
    pcLoad_i = 1'b0; start_i = 1'b0; pcInc_i = 1'b0;
    chk("prio_load_pc", pc_o, 16'h0100);
    chk("prio_load_busy", busy_o, 0);

    // start beats pcInc: branch runs, no +2
    start_i = 1'b1; pcInc_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; pcInc_i = 1'b0;
    chk("prio_start_busy", busy_o, 1);
    repeat (2) @(negedge clk_i);
    chk("prio_start_done", done_o, 1);
    chk("prio_start_pc", pc_o, 16'h0108);
    @(negedge clk_i);

    // table
    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while in LINK
    load_pc(16'h0100);
    start_branch(16'h0000, 16'h0010, 4'h0);
    @(negedge clk_i);
    chk("link_wr", lrWrEn_o, 1);
    chk("link_data", lrData_o, 16'h0100);
    #2 rst_i = 1'b1;
    #1;
    chk("link_rst_wr", lrWrEn_o, 0);
    chk("link_rst_pc", pc_o, 16'h0000);
    chk("link_rst_busy", busy_o, 0);
    chk("link_rst_lr", lrData_o, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("link_rst_quiet", {done_o, lrWrEn_o, busy_o}, 3'b000);
    end
    chk("link_rst_pc_after", pc_o, 16'h0000);

    // reset while in UPDATE
    load_pc(16'h0200);
    start_branch(16'h3C00, 16'h0040, 4'h0);
    @(negedge clk_i);
    chk("upd_busy", busy_o, 1);
    chk("upd_pc", pc_o, 16'h0200);
    #2 rst_i = 1'b1;
    #1;
    chk("upd_rst_pc", pc_o, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("upd_rst_pc_after", pc_o, 16'h0000);
    chk("upd_rst_idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
